// File: rtl/tick_frame_parser.sv
// Tick frame parser: SYNC, TYPE, PRICE_HI, PRICE_LO, SIZE, CHK byte frames -> top-of-book updates.
// Optional inter-byte timeout is enabled by defining TICK_TIMEOUT_EN.
//
// state  | meaning
// HUNT   | waiting for the sync byte
// TYPE   | expecting the update type byte
// PHI    | expecting price high byte
// PLO    | expecting price low byte
// SIZE   | expecting size byte
// CHK    | expecting XOR checksum byte
// OUT    | update presented downstream, input stalled
module tick_frame_parser #(
  parameter int         PRICE_W     = 16,
  parameter int         SIZE_W      = 8,
  parameter logic [7:0] SYNC_BYTE   = 8'hA5,
  parameter int         TIMEOUT_CYC = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         in_data,
  input  logic               in_val,
  output logic               in_rdy,
  output logic [1:0]         out_type,
  output logic [PRICE_W-1:0] out_price,
  output logic [SIZE_W-1:0]  out_size,
  output logic               out_val,
  input  logic               out_rdy,
  output logic [7:0]         err_cnt,
  output logic               busy
);

  typedef enum logic [2:0] {
    S_HUNT, S_TYPE, S_PHI, S_PLO, S_SIZE, S_CHK, S_OUT
  } state_t;

  state_t             state, state_nxt;
  logic               accept;
  logic               type_ok;
  logic               err_evt;
  logic               to_fire;
  logic [7:0]         chk_q;
  logic [1:0]         type_q;
  logic [PRICE_W-1:0] price_q;
  logic [SIZE_W-1:0]  size_q;
  logic               out_val_q;

  if (TIMEOUT_CYC < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 2");
  end

  assign in_rdy  = (state != S_OUT);
  assign busy    = (state != S_HUNT);
  assign accept  = in_val && in_rdy;
  assign type_ok = (in_data == 8'd1) || (in_data == 8'd2) || (in_data == 8'd3);

`ifdef TICK_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC);
  logic [TO_W-1:0] to_cnt;
  logic            in_frame;

  assign in_frame = (state == S_TYPE) || (state == S_PHI) || (state == S_PLO) ||
                    (state == S_SIZE) || (state == S_CHK);
  // An accepted byte in the terminal cycle takes priority over the timeout.
  assign to_fire  = in_frame && !accept && (to_cnt == TO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt <= '0;
    end else if (!in_frame || accept || to_fire) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 1'b1;
    end
  end
`else
  assign to_fire = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    err_evt   = 1'b0;
    case (state)
      S_HUNT: if (accept && in_data == SYNC_BYTE) state_nxt = S_TYPE;
      S_TYPE: begin
        if (accept) begin
          if (type_ok) begin
            state_nxt = S_PHI;
          end else begin
            state_nxt = S_HUNT;
            err_evt   = 1'b1;
          end
        end
      end
      S_PHI:  if (accept) state_nxt = S_PLO;
      S_PLO:  if (accept) state_nxt = S_SIZE;
      S_SIZE: if (accept) state_nxt = S_CHK;
      S_CHK: begin
        if (accept) begin
          if (in_data == chk_q) begin
            state_nxt = S_OUT;
          end else begin
            state_nxt = S_HUNT;
            err_evt   = 1'b1;
          end
        end
      end
      S_OUT:  if (out_rdy) state_nxt = S_HUNT;
      default: state_nxt = S_HUNT;
    endcase
    if (to_fire) begin
      state_nxt = S_HUNT;
      err_evt   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_HUNT;
      chk_q     <= '0;
      type_q    <= '0;
      price_q   <= '0;
      size_q    <= '0;
      out_val_q <= 1'b0;
      err_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      out_val_q <= (state_nxt == S_OUT);
      if (accept) begin
        case (state)
          S_TYPE: begin
            if (type_ok) begin
              type_q <= in_data[1:0];
              chk_q  <= in_data;
            end
          end
          S_PHI: begin
            price_q[15:8] <= in_data;
            chk_q         <= chk_q ^ in_data;
          end
          S_PLO: begin
            price_q[7:0] <= in_data;
            chk_q        <= chk_q ^ in_data;
          end
          S_SIZE: begin
            size_q <= in_data[SIZE_W-1:0];
            chk_q  <= chk_q ^ in_data;
          end
          default: ;
        endcase
      end
      if (err_evt && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end

  assign out_type  = type_q;
  assign out_price = price_q;
  assign out_size  = size_q;
  assign out_val   = out_val_q;

endmodule

// File: tb/tb_tick_frame_parser.sv
// Self-checking bench for tick_frame_parser: scoreboard of expected updates plus per-scenario checks.
module tb_tick_frame_parser;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_val;
  logic        in_rdy;
  logic [1:0]  out_type;
  logic [15:0] out_price;
  logic [7:0]  out_size;
  logic        out_val;
  logic        out_rdy;
  logic [7:0]  err_cnt;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int exp_err = 0;
  logic [25:0] exp_q[$];

  always #5 clk = ~clk;

  tick_frame_parser #(.TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_val(in_val), .in_rdy(in_rdy),
    .out_type(out_type), .out_price(out_price), .out_size(out_size),
    .out_val(out_val), .out_rdy(out_rdy), .err_cnt(err_cnt), .busy(busy)
  );

  // Scoreboard: pop and compare on every output handshake.
  always @(negedge clk) begin
    if (!rst && out_val && out_rdy) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_update: got type=%0d price=%h size=%h, expected none",
                 out_type, out_price, out_size);
      end else begin
        logic [25:0] e;
        e = exp_q.pop_front();
        if ({out_type, out_price, out_size} !== e) begin
          errors++;
          $display("FAIL update: got %h_%h_%h, expected %h_%h_%h",
                   out_type, out_price, out_size, e[25:24], e[23:8], e[7:0]);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, output int waits);
    waits = 0;
    @(negedge clk);
    in_data = b;
    in_val  = 1'b1;
    while (!in_rdy && waits < 100) begin
      @(negedge clk);
      waits++;
    end
    checks++;
    if (!in_rdy) begin
      errors++;
      $display("FAIL in_rdy_wait: got in_rdy=%b after %0d cycles, expected 1", in_rdy, waits);
    end
    @(posedge clk);
    #1;
    in_val = 1'b0;
  endtask

  task automatic send_bytes(input logic [47:0] f, input int n);
    int w;
    for (int i = 0; i < n; i++) send_byte(f[47 - 8*i -: 8], w);
  endtask

  task automatic push_exp(input logic [1:0] t, input logic [15:0] p, input logic [7:0] s);
    exp_q.push_back({t, p, s});
  endtask

  task automatic bump_err();
    if (exp_err < 255) exp_err++;
  endtask

  task automatic check_err(input string name);
    checks++;
    if (err_cnt !== exp_err[7:0]) begin
      errors++;
      $display("FAIL %s: err_cnt got %0d, expected %0d", name, err_cnt, exp_err);
    end
  endtask

  task automatic check_idle(input string name);
    checks++;
    if (busy !== 1'b0 || out_val !== 1'b0 || in_rdy !== 1'b1) begin
      errors++;
      $display("FAIL %s: busy/out_val/in_rdy got %b%b%b, expected 001", name, busy, out_val, in_rdy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_val = 1'b0; in_data = 8'h00; out_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_idle("reset_ctrl");
    checks++;
    if (out_type !== 2'd0 || out_price !== 16'd0 || out_size !== 8'd0 || err_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_fields: got %h %h %h %h, expected 0 0 0 0", out_type, out_price, out_size, err_cnt);
    end
  endtask

  task automatic test_bid();
    int w;
    push_exp(2'd1, 16'h1234, 8'h0A);
    send_bytes(48'hA5_01_12_34_0A_00, 5);
    checks++;
    if (out_val !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL bid_pre_chk: out_val/busy got %b%b, expected 01", out_val, busy);
    end
    send_byte(8'h2D, w);
    checks++;
    if (out_val !== 1'b1) begin
      errors++;
      $display("FAIL bid_latency: out_val got %b, expected 1", out_val);
    end
    check_err("bid_err");
    @(negedge clk);
    @(negedge clk);
    check_idle("bid_done");
  endtask

  task automatic test_backpressure();
    int w;
    int bad = 0;
    out_rdy = 1'b0;
    push_exp(2'd2, 16'h1240, 8'h05);
    send_bytes(48'hA5_02_12_40_05_55, 6);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_val !== 1'b1 || in_rdy !== 1'b0 || out_type !== 2'd2 ||
          out_price !== 16'h1240 || out_size !== 8'h05) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL hold_stable: got %0d unstable cycles, expected 0", bad);
    end
    checks++;
    if (exp_q.size() != 1) begin
      errors++;
      $display("FAIL hold_no_pop: got queue depth %0d, expected 1", exp_q.size());
    end
    @(posedge clk);
    #1 out_rdy = 1'b1;
    push_exp(2'd1, 16'h0010, 8'h20);
    send_byte(8'hA5, w);
    checks++;
    if (w != 1) begin
      errors++;
      $display("FAIL back_to_back: sync accepted after %0d waits, expected 1", w);
    end
    send_bytes(48'h01_00_10_20_31_00, 5);
  endtask

  task automatic test_bad_chk();
    send_bytes(48'hA5_03_00_64_01_00, 6);
    bump_err();
    check_err("bad_chk_err");
    check_idle("bad_chk_idle");
    push_exp(2'd3, 16'h0064, 8'h01);
    send_bytes(48'hA5_03_00_64_01_66, 6);
    check_err("bad_chk_recover");
  endtask

  task automatic test_junk_bad_type();
    send_bytes(48'h00_FF_00_00_00_00, 2);
    check_err("junk_ignored");
    check_idle("junk_hunt");
    send_bytes(48'hA5_07_00_00_00_00, 2);
    bump_err();
    check_err("bad_type");
    send_bytes(48'hA5_A5_00_00_00_00, 2);
    bump_err();
    check_err("sync_as_type");
    push_exp(2'd1, 16'h1234, 8'h0A);
    send_bytes(48'hA5_01_12_34_0A_2D, 6);
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 256; i++) begin
      send_bytes(48'hA5_00_00_00_00_00, 2);
      bump_err();
    end
    check_err("saturate");
    send_bytes(48'hA5_00_00_00_00_00, 2);
    bump_err();
    check_err("saturate_hold");
  endtask

  task automatic test_mid_reset();
    send_bytes(48'hA5_01_12_34_00_00, 4);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_err = 0;
    check_err("mid_reset_err");
    check_idle("mid_reset_idle");
    push_exp(2'd2, 16'hBEEF, 8'h77);
    send_bytes({8'hA5, 8'h02, 8'hBE, 8'hEF, 8'h77, 8'h02 ^ 8'hBE ^ 8'hEF ^ 8'h77}, 6);
  endtask

  task automatic test_timeout();
    send_bytes(48'hA5_01_00_00_00_00, 2);
`ifdef TICK_TIMEOUT_EN
    repeat (15) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL timeout_early: busy got %b, expected 1", busy);
    end
    check_err("timeout_early_err");
    @(posedge clk);
    #1;
    bump_err();
    check_err("timeout_fire");
    check_idle("timeout_hunt");
    push_exp(2'd1, 16'h1234, 8'h0A);
    send_bytes(48'hA5_01_12_34_0A_2D, 6);
`else
    repeat (40) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL no_timeout: busy got %b, expected 1", busy);
    end
    check_err("no_timeout_err");
    push_exp(2'd1, 16'h1234, 8'h0A);
    send_bytes(48'h12_34_0A_2D_00_00, 4);
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_bid();
    test_backpressure();
    test_bad_chk();
    test_junk_bad_type();
    test_saturation();
    test_mid_reset();
    test_timeout();
    repeat (4) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d updates still expected, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
